// File: rtl/if_pkg.sv
// if_pkg: shared FSM states, TRAP opcode and default reset PC for the fetch stage
package if_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, HALT, FAULT} if_state_e;
  localparam logic [0:5] TRAP_OPCODE = 6'h11;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: next-PC select (reg jump > imm26 jump > taken branch > sequential), word aligned
module if_next_pc (
  input  logic [0:31] pc,
  input  logic [0:25] imm26,
  input  logic        jump,
  input  logic        jump_use_reg,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [0:31] reg_target,
  output logic [0:31] next_pc
);
  logic [31:0] base, target;
  // word-offset immediates are sign-extended and scaled to bytes; result forced word aligned
  always_comb begin
    base = pc + 32'd4;
    target = (jump && jump_use_reg) ? reg_target
           : jump ? base + {{4{imm26[0]}}, imm26, 2'b00}
           : (branch && branch_taken) ? base + {{14{imm26[10]}}, imm26[10:25], 2'b00}
           : base;
    next_pc = target & ~32'd3;
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch FSM with timeout fault; IF_STAGE_HALT_DETECT_EN enables TRAP halt
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int IMEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic [0:31] imem_rdata,
  input  logic        imem_ready,
  output logic [0:31] instruction,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        BRANCH,
  input  logic        JUMP,
  input  logic        JUMP_USE_REG,
  input  logic        branch_taken,
  input  logic [0:31] reg_target,
  output logic [0:31] pc_plus4,
  output logic        fetch_fault,
  output logic        halted
);
  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  if_state_e state_q, state_d;
  logic [0:31] pc_q, pc_d, instr_q, instr_d, next_pc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fault_q, fault_d, halted_q, halted_d;

  if_next_pc u_next_pc (
    .pc(pc_q), .imm26(instr_q[6:31]), .jump(JUMP), .jump_use_reg(JUMP_USE_REG),
    .branch(BRANCH), .branch_taken(branch_taken), .reg_target(reg_target), .next_pc(next_pc)
  );

  // fetch/hold sequencing; HALT and FAULT have no exits so only reset leaves them
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    cnt_d = cnt_q;
    fault_d = fault_q;
    halted_d = halted_q;
    if (state_q == FETCH) begin
      if (imem_ready) begin
        instr_d = imem_rdata;
        state_d = HOLD;
        cnt_d = '0;
      end else if (cnt_q == CW'(IMEM_TIMEOUT - 1)) begin
        state_d = FAULT;
        fault_d = 1'b1;
      end else
        cnt_d = cnt_q + CW'(1);
    end else if (state_q == HOLD && advance) begin
`ifdef IF_STAGE_HALT_DETECT_EN
      if (instr_q[0:5] == TRAP_OPCODE) begin
        state_d = HALT;
        halted_d = 1'b1;
      end else
`endif
      begin
        pc_d = next_pc;
        state_d = FETCH;
      end
    end
  end

  // state registers with asynchronous reset discarding any pending fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      instr_q <= '0;
      cnt_q <= '0;
      fault_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      cnt_q <= cnt_d;
      fault_q <= fault_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req = (state_q == FETCH) && !reset;
  assign imem_addr = pc_q;
  assign instruction = instr_q;
  assign instr_valid = state_q == HOLD;
  assign pc_plus4 = pc_q + 32'd4;
  assign fetch_fault = fault_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed table-driven next-PC vectors plus reset, timeout, trap and ignore sequences
module tb_if_stage;
  logic clk, reset, imem_req, imem_ready, instr_valid, advance;
  logic BRANCH, JUMP, JUMP_USE_REG, branch_taken, fetch_fault, halted;
  logic [0:31] imem_addr, imem_rdata, instruction, reg_target, pc_plus4;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic br, j, ur, tk;
    logic [31:0] rt;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  if_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instruction(instruction),
    .instr_valid(instr_valid), .advance(advance), .BRANCH(BRANCH), .JUMP(JUMP),
    .JUMP_USE_REG(JUMP_USE_REG), .branch_taken(branch_taken), .reg_target(reg_target),
    .pc_plus4(pc_plus4), .fetch_fault(fetch_fault), .halted(halted)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    #1 reset = 0;
    #1;
  endtask

  task automatic fetch(input logic [31:0] data);
    check("req_in_fetch", 32'(imem_req), 32'd1);
    imem_ready = 1;
    imem_rdata = data;
    step();
    imem_ready = 0;
    imem_rdata = '0;
    check("valid_in_hold", 32'(instr_valid), 32'd1);
    check("held_instr", instruction, data);
  endtask

  task automatic adv(input logic br, input logic j, input logic ur, input logic tk, input logic [31:0] rt);
    BRANCH = br; JUMP = j; JUMP_USE_REG = ur; branch_taken = tk; reg_target = rt;
    advance = 1;
    step();
    advance = 0;
    BRANCH = 0; JUMP = 0; JUMP_USE_REG = 0; branch_taken = 0; reg_target = '0;
    check("bubble_after_adv", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h100, 32'h0000_FFFC, 1, 0, 0, 1, 0, 32'h0000_00F4};
    vecs[1] = '{32'h100, 32'h0000_FFFC, 1, 0, 0, 0, 0, 32'h0000_0104};
    vecs[2] = '{32'h100, 32'h0, 0, 1, 1, 0, 32'h2003, 32'h0000_2000};
    vecs[3] = '{32'h200, 32'h03FF_FFFF, 0, 1, 0, 0, 0, 32'h0000_0200};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0, 32'h0000_0000};
    vecs[5] = '{32'h1000, 32'h0000_0010, 0, 1, 0, 0, 0, 32'h0000_1044};
    vecs[6] = '{32'h1000, 32'h0100_0002, 1, 1, 0, 1, 0, 32'h0400_100C};
    vecs[7] = '{32'h1000, 32'h0, 0, 0, 1, 0, 32'h5000, 32'h0000_1004};
    vecs[8] = '{32'h0, 32'h0000_8000, 1, 0, 0, 1, 0, 32'hFFFE_0004};
    vecs[9] = '{32'h10, 32'h0, 0, 1, 1, 0, 32'h7, 32'h0000_0004};
    reset = 0; imem_ready = 0; imem_rdata = '0; advance = 0;
    BRANCH = 0; JUMP = 0; JUMP_USE_REG = 0; branch_taken = 0; reg_target = '0;
    #1 reset = 1;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    step();
    reset = 0;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    fetch(32'h1234_5678);
    check("pc_plus4_0", pc_plus4, 32'h4);
    adv(0, 0, 0, 0, 0);
    check("seq_addr", imem_addr, 32'h4);
    advance = 1;
    step();
    advance = 0;
    check("adv_ignored_addr", imem_addr, 32'h4);
    check("adv_ignored_valid", 32'(instr_valid), 32'd0);
    fetch(32'h0);
    imem_ready = 1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ready = 0;
    check("ready_ignored_instr", instruction, 32'h0);
    check("ready_ignored_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      adv(0, 1, 1, 0, vecs[i].pc);
      check("set_pc", imem_addr, vecs[i].pc);
      fetch(vecs[i].instr);
      check("vec_pc_plus4", pc_plus4, vecs[i].pc + 32'd4);
      adv(vecs[i].br, vecs[i].j, vecs[i].ur, vecs[i].tk, vecs[i].rt);
      check($sformatf("vec%0d_next", i), imem_addr, vecs[i].exp);
      fetch(32'h0);
    end
    adv(0, 1, 1, 0, 32'h300);
    fetch(32'h4400_0000);
    adv(0, 0, 0, 0, 0);
`ifdef IF_STAGE_HALT_DETECT_EN
    check("trap_halted", 32'(halted), 32'd1);
    check("trap_no_req", 32'(imem_req), 32'd0);
    step();
    step();
    check("trap_stays_halted", 32'(imem_req), 32'd0);
`else
    check("trap_next_addr", imem_addr, 32'h304);
    check("trap_not_halted", 32'(halted), 32'd0);
    check("trap_req", 32'(imem_req), 32'd1);
`endif
    do_reset();
    for (int i = 0; i < 7; i++) step();
    check("pre_timeout_fault", 32'(fetch_fault), 32'd0);
    check("pre_timeout_req", 32'(imem_req), 32'd1);
    step();
    check("timeout_fault", 32'(fetch_fault), 32'd1);
    check("timeout_req", 32'(imem_req), 32'd0);
    imem_ready = 1;
    advance = 1;
    for (int i = 0; i < 3; i++) step();
    imem_ready = 0;
    advance = 0;
    check("fault_sticky", 32'(fetch_fault), 32'd1);
    check("fault_no_valid", 32'(instr_valid), 32'd0);
    check("fault_no_req", 32'(imem_req), 32'd0);
    do_reset();
    check("fault_cleared", 32'(fetch_fault), 32'd0);
    fetch(32'h0);
    adv(0, 1, 1, 0, 32'h40);
    check("hold_pc_40", imem_addr, 32'h40);
    fetch(32'hABCD_0000);
    #2 reset = 1;
    #1;
    check("midhold_rst_valid", 32'(instr_valid), 32'd0);
    check("midhold_rst_req", 32'(imem_req), 32'd0);
    check("midhold_rst_instr", instruction, 32'h0);
    check("midhold_rst_addr", imem_addr, 32'h0);
    check("midhold_rst_pc4", pc_plus4, 32'h4);
    reset = 0;
    #1;
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    step();
    fetch(32'h0000_0001);
    adv(0, 0, 0, 0, 0);
    check("post_rst_seq", imem_addr, 32'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
